// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MEM-stage data-memory access controller with WB register
//                   stage, request/ack handshake and bounded-wait abort.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_memToReg,
  input  logic        i_regWrite,
  input  logic [31:0] i_aluResult,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_stall,
  output logic        o_memReq,
  output logic        o_memWe,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWdata,
  input  logic        i_memAck,
  input  logic [31:0] i_memRdata,
  output logic        o_regWrite,
  output logic        o_memToReg,
  output logic [31:0] o_wbData,
  output logic [4:0]  o_wbRd,
  output logic        o_busErr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       timeout_hit;

  assign mem_op      = i_memRead | i_memWrite;
  assign timeout_hit = (wait_cnt == LAST_WAIT);

  // Stall is gated by reset so the pipeline is released the instant reset rises.
  assign o_stall = ~i_rst &
                   (((state == IDLE) & mem_op) |
                    ((state == BUSY) & ~i_memAck & ~timeout_hit));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      o_memReq   <= 1'b0;
      o_memWe    <= 1'b0;
      o_memAddr  <= 32'd0;
      o_memWdata <= 32'd0;
      o_regWrite <= 1'b0;
      o_memToReg <= 1'b0;
      o_wbData   <= 32'd0;
      o_wbRd     <= 5'd0;
      o_busErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= BUSY;
            wait_cnt   <= 8'd0;
            o_memReq   <= 1'b1;
            o_memWe    <= i_memWrite & ~i_memRead;
            o_memAddr  <= i_aluResult;
            o_memWdata <= i_wdata;
            o_regWrite <= 1'b0;
          end else begin
            o_regWrite <= i_regWrite;
            o_memToReg <= i_memToReg;
            o_wbData   <= i_aluResult;
            o_wbRd     <= i_rd;
          end
        end
        BUSY: begin
          // Ack takes priority over an expiring wait counter.
          if (i_memAck) begin
            state      <= IDLE;
            o_memReq   <= 1'b0;
            o_memWe    <= 1'b0;
            o_regWrite <= i_regWrite;
            o_memToReg <= i_memToReg;
            o_wbRd     <= i_rd;
            o_wbData   <= i_memToReg ? i_memRdata : i_aluResult;
          end else if (timeout_hit) begin
            state      <= IDLE;
            o_memReq   <= 1'b0;
            o_memWe    <= 1'b0;
            o_busErr   <= 1'b1;
            o_regWrite <= 1'b0;
            o_wbData   <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random ALU/load/store
// traffic checked against a transaction-level timing model.
`default_nettype none

module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        memRead, memWrite, memToReg, regWrite;
  logic [31:0] aluResult, wdata;
  logic [4:0]  rd;
  logic        stall, memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic        memAck;
  logic [31:0] memRdata;
  logic        wbRegWrite, wbMemToReg;
  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic        busErr;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_err = 1'b0;

  mem_access_ctrl #(.TIMEOUT(T)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_memRead  (memRead),
    .i_memWrite (memWrite),
    .i_memToReg (memToReg),
    .i_regWrite (regWrite),
    .i_aluResult(aluResult),
    .i_wdata    (wdata),
    .i_rd       (rd),
    .o_stall    (stall),
    .o_memReq   (memReq),
    .o_memWe    (memWe),
    .o_memAddr  (memAddr),
    .o_memWdata (memWdata),
    .i_memAck   (memAck),
    .i_memRdata (memRdata),
    .o_regWrite (wbRegWrite),
    .o_memToReg (wbMemToReg),
    .o_wbData   (wbData),
    .o_wbRd     (wbRd),
    .o_busErr   (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Non-memory instruction: one-cycle pass-through to WB; memory ack must be ignored.
  task automatic alu_op(input logic rw, input logic m2r, input logic [31:0] a, input logic [4:0] r);
    memRead = 1'b0; memWrite = 1'b0;
    regWrite = rw; memToReg = m2r; aluResult = a; rd = r;
    wdata = $urandom; memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
    @(negedge clk);
    chk("alu_stall", stall, 1'b0);
    @(posedge clk); #1;
    memAck = 1'b0;
    chk("alu_req", memReq, 1'b0);
    chk("alu_regwrite", wbRegWrite, rw);
    chk("alu_memtoreg", wbMemToReg, m2r);
    chk("alu_wbdata", wbData, a);
    chk("alu_wbrd", wbRd, r);
    chk("alu_buserr", busErr, exp_err);
  endtask

  // Memory op whose ack arrives on BUSY cycle d (0 = first BUSY cycle); d >= T means
  // the access times out after T BUSY cycles.
  task automatic mem_op(input logic rd_f, input logic wr_f, input logic rw, input logic m2r,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic [4:0] r, input int d);
    logic exp_we;
    int   i;
    int   stall_cycles;
    int   req_cycles;
    bit   done;
    bit   acked;
    exp_we = wr_f & ~rd_f;
    acked  = (d < T);
    memRead = rd_f; memWrite = wr_f; regWrite = rw; memToReg = m2r;
    aluResult = addr; wdata = wd; rd = r;
    memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
    stall_cycles = 0; req_cycles = 0;
    @(negedge clk);
    chk("op_stall_idle", stall, 1'b1);
    if (stall) stall_cycles++;
    @(posedge clk); #1;
    i = 0; done = 0;
    while (!done) begin
      memAck   = (i == d);
      memRdata = (i == d) ? rdat : $urandom;
      @(negedge clk);
      chk("busy_req", memReq, 1'b1);
      chk("busy_we", memWe, exp_we);
      chk("busy_addr", memAddr, addr);
      chk("busy_wdata", memWdata, wd);
      chk("busy_regwrite", wbRegWrite, 1'b0);
      chk("busy_stall", stall, ((i == d) || (i == T - 1)) ? 1'b0 : 1'b1);
      if (stall) stall_cycles++;
      if (memReq) req_cycles++;
      done = (i == d) || (i == T - 1);
      @(posedge clk); #1;
      i++;
    end
    memAck = 1'b0;
    chk("op_stall_cycles", stall_cycles, acked ? d + 1 : T);
    chk("op_req_cycles", req_cycles, acked ? d + 1 : T);
    chk("op_req_drop", memReq, 1'b0);
    if (acked) begin
      chk("wb_regwrite", wbRegWrite, rw);
      chk("wb_memtoreg", wbMemToReg, m2r);
      chk("wb_rd", wbRd, r);
      chk("wb_data", wbData, m2r ? rdat : addr);
    end else begin
      exp_err = 1'b1;
      chk("to_regwrite", wbRegWrite, 1'b0);
      chk("to_wbdata", wbData, 32'd0);
    end
    chk("op_buserr", busErr, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    memRead = 0; memWrite = 0; memToReg = 0; regWrite = 0;
    aluResult = 0; wdata = 0; rd = 0; memAck = 0; memRdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", memReq, 1'b0);
    chk("rst_we", memWe, 1'b0);
    chk("rst_addr", memAddr, 32'd0);
    chk("rst_wdata", memWdata, 32'd0);
    chk("rst_regwrite", wbRegWrite, 1'b0);
    chk("rst_memtoreg", wbMemToReg, 1'b0);
    chk("rst_wbdata", wbData, 32'd0);
    chk("rst_wbrd", wbRd, 5'd0);
    chk("rst_buserr", busErr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    alu_op(1'b1, 1'b0, 32'h1234, 5'd7);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 3);
    mem_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h55AA, 32'h0, 5'd0, 0);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 32'h0, 5'd9, 255);
    alu_op(1'b1, 1'b0, 32'hCAFE, 5'd12);

    // Reset asserted between edges while an access is outstanding.
    memRead = 1'b1; memWrite = 1'b0; regWrite = 1'b1; memToReg = 1'b1;
    aluResult = 32'h400; rd = 5'd4; memAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_req", memReq, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_req", memReq, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_regwrite", wbRegWrite, 1'b0);
    chk("midrst_buserr", busErr, 1'b0);
    exp_err = 1'b0;
    memRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 32'hFFFF, 32'h13579BDF, 5'd5, 1);

    for (int k = 0; k < 60; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0)
        alu_op(1'($urandom), 1'($urandom), $urandom, 5'($urandom));
      else
        mem_op(kind != 2, kind >= 2, 1'($urandom), 1'($urandom), $urandom, $urandom,
               $urandom, 5'($urandom), $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max BUSY cycles without ack before the access is aborted (range 1..255).
REQ-002 SHALL have ports:
  i_clk  in  1  sole clock, rising edge
  i_rst  in  1  reset, asynchronous, active-high
  i_memRead  in  1  MEM-stage control: load
  i_memWrite  in  1  MEM-stage control: store
  i_memToReg  in  1  MEM-stage control: writeback selects memory data
  i_regWrite  in  1  MEM-stage control: register write enable
  i_aluResult  in  32  address for load/store; writeback data otherwise
  i_wdata  in  32  store data
  i_rd  in  5  destination register
  o_stall  out  1  hold upstream pipeline (combinational)
  o_memReq  out  1  data-memory request (registered)
  o_memWe  out  1  1=write, 0=read (registered)
  o_memAddr  out  32  memory address (registered)
  o_memWdata  out  32  memory write data (registered)
  i_memAck  in  1  memory completion, sampled on rising edge
  i_memRdata  in  32  read data, valid when i_memAck=1
  o_regWrite  out  1  WB-stage control (registered)
  o_memToReg  out  1  WB-stage control (registered)
  o_wbData  out  32  WB data (registered)
  o_wbRd  out  5  WB destination (registered)
  o_busErr  out  1  sticky timeout flag

Function
REQ-003 SHALL implement states IDLE and BUSY; BUSY entered only from IDLE.
REQ-004 IDLE, i_memRead=i_memWrite=0: every edge loads o_regWrite<=i_regWrite, o_memToReg<=i_memToReg, o_wbData<=i_aluResult, o_wbRd<=i_rd; latency 1 cycle.
REQ-005 IDLE, i_memRead|i_memWrite=1: next edge -> BUSY, o_memReq<=1, o_memWe<=i_memWrite&~i_memRead, o_memAddr<=i_aluResult, o_memWdata<=i_wdata, o_regWrite<=0 (bubble).
REQ-006 i_memRead and i_memWrite both 1: read performed, write suppressed (o_memWe=0).
REQ-007 o_stall SHALL be 1 when (IDLE and memory op at inputs) or (BUSY and i_memAck=0 and timeout not reached); 0 otherwise.
REQ-008 o_memAddr, o_memWdata, o_memWe SHALL stay constant while o_memReq=1; inputs are held by upstream during stall.
REQ-009 BUSY with i_memAck=1: next edge -> IDLE, o_memReq<=0, o_regWrite<=i_regWrite, o_memToReg<=i_memToReg, o_wbRd<=i_rd, o_wbData<=(i_memToReg ? i_memRdata : i_aluResult).
REQ-010 Minimum memory-op occupancy 2 cycles (request cycle + ack cycle); each wait cycle adds 1.
REQ-011 8-bit wait counter cleared on BUSY entry, increments per BUSY cycle without ack; at count==TIMEOUT-1 without ack: next edge -> IDLE, o_memReq<=0, o_busErr<=1, o_regWrite<=0, o_wbData<=0, o_stall=0 in that cycle.
REQ-012 Ack and timeout in same cycle: ack wins, no error.
REQ-013 i_memAck in IDLE SHALL be ignored.
REQ-014 Back-to-back memory ops: the IDLE cycle after completion starts the next op; no cycle merged.

Reset
REQ-015 i_rst=1 SHALL immediately force IDLE, counter 0, o_memReq/o_memWe/o_regWrite/o_memToReg/o_busErr=0, o_memAddr/o_memWdata/o_wbData=0, o_wbRd=0, independent of i_clk.
REQ-016 Reset during BUSY SHALL abort the access with no WB write; o_busErr cleared only by reset.

Verification
REQ-017 ALU op: i_regWrite=1, i_aluResult=0x1234, i_rd=7 -> next edge o_regWrite=1, o_wbData=0x1234, o_wbRd=7, o_stall=0 throughout.
REQ-018 Load addr 0x100, ack 3 cycles after o_memReq rises, i_memRdata=0xDEADBEEF -> o_stall=1 for 4 cycles, o_wbData=0xDEADBEEF, o_regWrite=1, o_memWe=0.
REQ-019 Store addr 0x200 data 0x55AA, immediate ack -> o_memWe=1, o_memWdata=0x55AA for 1 cycle, o_regWrite=0, 2-cycle occupancy.
REQ-020 Load, no ack, TIMEOUT=4 -> o_memReq high 4 cycles then drops, o_busErr=1 sticky, o_regWrite=0.
REQ-021 Assert i_rst mid-BUSY between edges -> o_memReq and o_stall drop at once; load with read+write both set after reset performs read only.
